// File: rtl/imem_loader_if.sv
// imem_loader_if
//   Bundles the fetch port and the program-load port of imem_loader.
//   master : the CPU/loader side (drives requests and load words).
//   slave  : the memory side (imem_loader itself).
//
//   Fetch port : fetch_req, fetch_addr -> fetch_ready, fetch_valid,
//                fetch_data, fetch_err
//   Load port  : load_start, load_base, load_valid, load_data, load_last
//                -> load_ready, load_count, load_err
//   Status     : busy
interface imem_loader_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
);
    logic                  fetch_req;
    logic [ADDR_WIDTH-1:0] fetch_addr;
    logic                  fetch_ready;
    logic                  fetch_valid;
    logic [DATA_WIDTH-1:0] fetch_data;
    logic                  fetch_err;

    logic                  load_start;
    logic [ADDR_WIDTH-1:0] load_base;
    logic                  load_valid;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  load_last;
    logic                  load_ready;
    logic [ADDR_WIDTH:0]   load_count;
    logic                  load_err;

    logic                  busy;

    modport master (
        output fetch_req, fetch_addr,
        output load_start, load_base, load_valid, load_data, load_last,
        input  fetch_ready, fetch_valid, fetch_data, fetch_err,
        input  load_ready, load_count, load_err, busy
    );

    modport slave (
        input  fetch_req, fetch_addr,
        input  load_start, load_base, load_valid, load_data, load_last,
        output fetch_ready, fetch_valid, fetch_data, fetch_err,
        output load_ready, load_count, load_err, busy
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader
//   Instruction memory with a one-cycle registered fetch port and a
//   streaming program-load port. After reset every word is initialised
//   (word i = i, or all zero), then fetches are served in IDLE. A load
//   burst writes consecutive words starting at load_base; words falling
//   beyond DEPTH are dropped and flagged in the sticky load_err.
//
//   Ports:
//     clk  : rising-edge clock
//     rst  : synchronous, active-high reset (restarts initialisation)
//     bus  : imem_loader_if.slave (fetch port, load port, busy)
module imem_loader #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 8,
    parameter int DEPTH         = 256,
    parameter bit INIT_IDENTITY = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    imem_loader_if.slave  bus
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PTR_W = ADDR_WIDTH + 1;
    localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_P  = PTR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_INIT,
        S_IDLE,
        S_LOAD
    } state_t;

    state_t state, state_n;

    logic [DATA_WIDTH-1:0] ram [DEPTH];

    // ptr is the init pointer in INIT and the write pointer in LOAD; one
    // extra bit lets it run past DEPTH-1 without wrapping back onto word 0.
    logic [PTR_W-1:0]      ptr;
    logic [PTR_W-1:0]      load_count_r;
    logic                  load_err_r;

    logic                  fetch_vld_p1;
    logic [DATA_WIDTH-1:0] fetch_data_p1;
    logic                  fetch_err_p1;

    logic                  fetch_ready_c;
    logic                  load_ready_c;
    logic                  busy_c;
    logic                  we_c;
    logic [IDX_W-1:0]      waddr_c;
    logic [DATA_WIDTH-1:0] wdata_c;
    logic                  fetch_acc;
    logic                  fetch_in_range;
    logic                  ptr_in_range;
    logic                  base_in_range;

    function automatic logic [PTR_W-1:0] sat_inc(input logic [PTR_W-1:0] v);
        return (&v) ? v : v + PTR_W'(1);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] init_word(input logic [PTR_W-1:0] idx);
        return INIT_IDENTITY ? DATA_WIDTH'(idx) : '0;
    endfunction

    assign fetch_in_range = ({1'b0, bus.fetch_addr} < DEPTH_P);
    assign base_in_range  = ({1'b0, bus.load_base} < DEPTH_P);
    assign ptr_in_range   = (ptr < DEPTH_P);
    assign fetch_acc      = fetch_ready_c && bus.fetch_req;

    always_ff @(posedge clk) begin
        if (rst) state <= S_INIT;
        else     state <= state_n;
    end

    always_comb begin
        state_n       = state;
        fetch_ready_c = 1'b0;
        load_ready_c  = 1'b0;
        busy_c        = 1'b0;
        we_c          = 1'b0;
        waddr_c       = ptr[IDX_W-1:0];
        wdata_c       = bus.load_data;
        case (state)
            S_INIT: begin
                busy_c  = 1'b1;
                we_c    = 1'b1;
                wdata_c = init_word(ptr);
                if (ptr == LAST_P) state_n = S_IDLE;
            end
            S_IDLE: begin
                fetch_ready_c = 1'b1;
                if (bus.load_start) state_n = S_LOAD;
            end
            S_LOAD: begin
                busy_c       = 1'b1;
                load_ready_c = 1'b1;
                if (bus.load_valid) begin
                    we_c = ptr_in_range;
                    if (bus.load_last) state_n = S_IDLE;
                end
            end
            default: state_n = S_INIT;
        endcase
        if (rst) we_c = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (we_c) ram[waddr_c] <= wdata_c;
    end

    // p1: registered fetch result and load bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr           <= '0;
            load_count_r  <= '0;
            load_err_r    <= 1'b0;
            fetch_vld_p1  <= 1'b0;
            fetch_data_p1 <= '0;
            fetch_err_p1  <= 1'b0;
        end else begin
            fetch_vld_p1 <= fetch_acc;
            if (fetch_acc) begin
                if (fetch_in_range) begin
                    fetch_data_p1 <= ram[bus.fetch_addr[IDX_W-1:0]];
                    fetch_err_p1  <= 1'b0;
                end else begin
                    fetch_data_p1 <= '0;
                    fetch_err_p1  <= 1'b1;
                end
            end
            case (state)
                S_INIT: ptr <= ptr + PTR_W'(1);
                S_IDLE: begin
                    if (bus.load_start) begin
                        ptr          <= {1'b0, bus.load_base};
                        load_count_r <= '0;
                        load_err_r   <= !base_in_range;
                    end
                end
                S_LOAD: begin
                    if (bus.load_valid) begin
                        ptr          <= sat_inc(ptr);
                        load_count_r <= sat_inc(load_count_r);
                        if (!ptr_in_range) load_err_r <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.fetch_ready = fetch_ready_c;
    assign bus.fetch_valid = fetch_vld_p1;
    assign bus.fetch_data  = fetch_data_p1;
    assign bus.fetch_err   = fetch_err_p1;
    assign bus.load_ready  = load_ready_c;
    assign bus.load_count  = load_count_r;
    assign bus.load_err    = load_err_r;
    assign bus.busy        = busy_c;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
//   Directed bench for imem_loader. Two instances share clk/rst:
//   dut_a (DEPTH=256) and dut_b (DEPTH=200, for out-of-range cases).
//   Expected fetch results are queued when a request is driven and
//   compared when fetch_valid appears.
module tb_imem_loader;

    localparam int DW = 32;
    localparam int AW = 8;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          err;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    imem_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_a ();
    imem_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_b ();

    imem_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(256), .INIT_IDENTITY(1'b1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    imem_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(200), .INIT_IDENTITY(1'b1)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    exp_t qa[$];
    exp_t qb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitors: pop one expectation per fetch_valid pulse.
    always @(negedge clk) begin : mon_a
        exp_t e;
        if (bus_a.fetch_valid === 1'b1) begin
            check("a_sb_nonempty", 64'(qa.size() != 0), 64'd1);
            if (qa.size() != 0) begin
                e = qa.pop_front();
                check("a_fetch_data", 64'(bus_a.fetch_data), 64'(e.data));
                check("a_fetch_err", 64'(bus_a.fetch_err), 64'(e.err));
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (bus_b.fetch_valid === 1'b1) begin
            check("b_sb_nonempty", 64'(qb.size() != 0), 64'd1);
            if (qb.size() != 0) begin
                e = qb.pop_front();
                check("b_fetch_data", 64'(bus_b.fetch_data), 64'(e.data));
                check("b_fetch_err", 64'(bus_b.fetch_err), 64'(e.err));
            end
        end
    end

    // Called just after a falling edge; returns one falling edge later.
    task automatic fetch_a(input logic [AW-1:0] addr, input logic [DW-1:0] d, input logic e);
        bus_a.fetch_req  = 1'b1;
        bus_a.fetch_addr = addr;
        check("a_fetch_ready", 64'(bus_a.fetch_ready), 64'd1);
        qa.push_back(exp_t'{d, e});
        @(negedge clk);
        bus_a.fetch_req = 1'b0;
        check("a_fetch_valid_latency", 64'(bus_a.fetch_valid), 64'd1);
    endtask

    task automatic fetch_b(input logic [AW-1:0] addr, input logic [DW-1:0] d, input logic e);
        bus_b.fetch_req  = 1'b1;
        bus_b.fetch_addr = addr;
        check("b_fetch_ready", 64'(bus_b.fetch_ready), 64'd1);
        qb.push_back(exp_t'{d, e});
        @(negedge clk);
        bus_b.fetch_req = 1'b0;
        check("b_fetch_valid_latency", 64'(bus_b.fetch_valid), 64'd1);
    endtask

    task automatic load_word_a(input logic [DW-1:0] d, input logic last);
        bus_a.load_valid = 1'b1;
        bus_a.load_data  = d;
        bus_a.load_last  = last;
        @(negedge clk);
        bus_a.load_valid = 1'b0;
        bus_a.load_last  = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin : stim
        rst = 1'b1;
        bus_a.fetch_req = 1'b0; bus_a.fetch_addr = '0;
        bus_a.load_start = 1'b0; bus_a.load_base = '0;
        bus_a.load_valid = 1'b0; bus_a.load_data = '0; bus_a.load_last = 1'b0;
        bus_b.fetch_req = 1'b0; bus_b.fetch_addr = '0;
        bus_b.load_start = 1'b0; bus_b.load_base = '0;
        bus_b.load_valid = 1'b0; bus_b.load_data = '0; bus_b.load_last = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_fetch_valid", 64'(bus_a.fetch_valid), 64'd0);
        check("rst_fetch_data",  64'(bus_a.fetch_data),  64'd0);
        check("rst_fetch_err",   64'(bus_a.fetch_err),   64'd0);
        check("rst_fetch_ready", 64'(bus_a.fetch_ready), 64'd0);
        check("rst_load_ready",  64'(bus_a.load_ready),  64'd0);
        check("rst_load_count",  64'(bus_a.load_count),  64'd0);
        check("rst_load_err",    64'(bus_a.load_err),    64'd0);
        check("rst_busy",        64'(bus_a.busy),        64'd1);

        // Init sweep: busy must fall exactly after DEPTH edges
        rst = 1'b0;
        for (int i = 1; i <= 256; i++) begin
            @(negedge clk);
            if (i == 199) check("b_busy_before_done", 64'(bus_b.busy), 64'd1);
            if (i == 200) check("b_busy_done", 64'(bus_b.busy), 64'd0);
            if (i == 255) begin
                check("a_busy_before_done", 64'(bus_a.busy), 64'd1);
                check("a_ready_before_done", 64'(bus_a.fetch_ready), 64'd0);
            end
        end
        check("a_busy_done", 64'(bus_a.busy), 64'd0);

        // Identity contents
        fetch_a(8'd0,   32'd0,   1'b0);
        fetch_a(8'd7,   32'd7,   1'b0);
        fetch_a(8'd255, 32'd255, 1'b0);

        // Back-to-back fetches, then single-pulse check
        fetch_a(8'd3, 32'd3, 1'b0);
        fetch_a(8'd4, 32'd4, 1'b0);
        @(negedge clk);
        check("a_valid_single_pulse", 64'(bus_a.fetch_valid), 64'd0);

        // Out-of-range fetch on DEPTH=200
        fetch_b(8'd220, 32'd0,   1'b1);
        fetch_b(8'd199, 32'd199, 1'b0);

        // Load burst at base 10
        bus_a.load_start = 1'b1;
        bus_a.load_base  = 8'd10;
        @(negedge clk);
        bus_a.load_start = 1'b0;
        check("load_ready_in_load", 64'(bus_a.load_ready), 64'd1);
        check("fetch_ready_in_load", 64'(bus_a.fetch_ready), 64'd0);
        check("busy_in_load", 64'(bus_a.busy), 64'd1);
        load_word_a(32'hA, 1'b0);
        load_word_a(32'hB, 1'b0);
        load_word_a(32'hC, 1'b1);
        check("load_ready_after_last", 64'(bus_a.load_ready), 64'd0);
        check("fetch_ready_after_last", 64'(bus_a.fetch_ready), 64'd1);
        check("load_count_3", 64'(bus_a.load_count), 64'd3);
        check("load_err_0", 64'(bus_a.load_err), 64'd0);
        fetch_a(8'd10, 32'hA, 1'b0);
        fetch_a(8'd11, 32'hB, 1'b0);
        fetch_a(8'd12, 32'hC, 1'b0);
        fetch_a(8'd13, 32'd13, 1'b0);

        // Overflow burst at base 254, with a simultaneous fetch of old data
        bus_a.load_start = 1'b1;
        bus_a.load_base  = 8'd254;
        fetch_a(8'd11, 32'hB, 1'b0);
        bus_a.load_start = 1'b0;
        check("ovf_load_ready", 64'(bus_a.load_ready), 64'd1);
        check("ovf_err_at_start", 64'(bus_a.load_err), 64'd0);
        for (int i = 0; i < 4; i++) load_word_a(32'h100 + 32'(i), (i == 3));
        check("ovf_load_err", 64'(bus_a.load_err), 64'd1);
        check("ovf_load_count", 64'(bus_a.load_count), 64'd4);
        check("ovf_back_idle", 64'(bus_a.fetch_ready), 64'd1);
        fetch_a(8'd254, 32'h100, 1'b0);
        fetch_a(8'd255, 32'h101, 1'b0);
        fetch_a(8'd0,   32'd0,   1'b0);
        check("ovf_err_sticky", 64'(bus_a.load_err), 64'd1);

        // Load base beyond DEPTH on the 200-word instance
        bus_b.load_start = 1'b1;
        bus_b.load_base  = 8'd210;
        @(negedge clk);
        bus_b.load_start = 1'b0;
        check("b_base_err_immediate", 64'(bus_b.load_err), 64'd1);
        bus_b.load_valid = 1'b1; bus_b.load_data = 32'hDEAD; bus_b.load_last = 1'b1;
        @(negedge clk);
        bus_b.load_valid = 1'b0; bus_b.load_last = 1'b0;
        check("b_base_count", 64'(bus_b.load_count), 64'd1);
        check("b_base_idle", 64'(bus_b.fetch_ready), 64'd1);

        // New load clears load_err; reset mid-load re-initialises
        bus_a.load_start = 1'b1;
        bus_a.load_base  = 8'd5;
        @(negedge clk);
        bus_a.load_start = 1'b0;
        check("restart_clears_err", 64'(bus_a.load_err), 64'd0);
        load_word_a(32'h55, 1'b0);
        load_word_a(32'h66, 1'b0);
        check("midload_count", 64'(bus_a.load_count), 64'd2);
        rst = 1'b1;
        bus_a.load_valid = 1'b1; bus_a.load_data = 32'h77;
        @(negedge clk);
        rst = 1'b0;
        bus_a.load_valid = 1'b0;
        check("midrst_busy", 64'(bus_a.busy), 64'd1);
        check("midrst_load_ready", 64'(bus_a.load_ready), 64'd0);
        check("midrst_load_err", 64'(bus_a.load_err), 64'd0);
        check("midrst_load_count", 64'(bus_a.load_count), 64'd0);
        repeat (256) @(negedge clk);
        check("midrst_busy_done", 64'(bus_a.busy), 64'd0);
        fetch_a(8'd5, 32'd5, 1'b0);
        fetch_a(8'd6, 32'd6, 1'b0);
        fetch_a(8'd7, 32'd7, 1'b0);

        @(negedge clk);
        check("a_sb_drained", 64'(qa.size()), 64'd0);
        check("b_sb_drained", 64'(qb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
